mod_enc_add_round_key: RTL and testbench

//  AES-256 encryption AddRoundKey stage: XORs a 128-bit state with a 128-bit round key.

---
 rtl/mod_enc_add_round_key.sv | 115 +++++++++++
 tb/tb_mod_enc_add_round_key.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mod_enc_add_round_key.sv
// AES AddRoundKey stage: byte-serial XOR of a captured 128-bit state with a captured round key.
// Latency: ok rises 16 clocks after the start edge (one result byte per clock).
// Backpressure: starts only when reg163 is ready; holds ok/o until reg163 drops its ready flag.
module mod_enc_add_round_key #(
   parameter int N = 16
) (
   input  logic                clk,
   input  logic                resetn,        // active-high despite the name
   input  logic                startBit,
   input  logic                reg163_status,
   input  logic                reg162_status,
   input  logic                rd_comp,
   input  logic [N-1:0][7:0]   p,
   input  logic [127:0]        k,
   input  logic [3:0]          round,
   output logic [N-1:0][7:0]   o,
   output logic                ok
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N-1:0][7:0]   o_q, o_d;
   logic                ok_q, ok_d;
   logic [N-1:0][7:0]   preg_q, preg_d;
   logic [N-1:0][7:0]   kreg_q, kreg_d;
   logic                start;
   logic                last_byte;

   // Round 0 takes its state straight from the plaintext, so reg162 need not be full.
   assign start     = startBit & rd_comp & reg163_status & ((round == 4'd0) | reg162_status);
   assign last_byte = (cnt_q == CW'(N - 1));

   // State register.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: once started, a block always runs to completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)          state_d = S_RUN;
         S_RUN:   if (last_byte)      state_d = S_DONE;
         S_DONE:  if (!reg163_status) state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   // Datapath/output logic: operand capture on start, one XORed byte per RUN cycle.
   always_comb begin
      cnt_d  = cnt_q;
      o_d    = o_q;
      ok_d   = ok_q;
      preg_d = preg_q;
      kreg_d = kreg_q;
      case (state_q)
         S_IDLE: begin
            ok_d = 1'b0;
            if (start) begin
               preg_d = p;
               kreg_d = k;
               cnt_d  = '0;
               o_d    = '0;
            end
         end
         S_RUN: begin
            o_d[cnt_q] = preg_q[cnt_q] ^ kreg_q[cnt_q];
            cnt_d      = cnt_q + CW'(1);
            if (last_byte) begin
               ok_d = 1'b1;
            end
         end
         S_DONE: begin
            // ok drops on the same edge the FSM returns to IDLE; o keeps the last result.
            ok_d = reg163_status;
         end
         default: begin
            ok_d = 1'b0;
         end
      endcase
   end

   // Datapath registers; reset aborts any block in flight.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         cnt_q  <= '0;
         o_q    <= '0;
         ok_q   <= 1'b0;
         preg_q <= '0;
         kreg_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         o_q    <= o_d;
         ok_q   <= ok_d;
         preg_q <= preg_d;
         kreg_q <= kreg_d;
      end
   end

   assign o  = o_q;
   assign ok = ok_q;

endmodule

// File: tb/tb_mod_enc_add_round_key.sv
// Directed bench for mod_enc_add_round_key: reset, start gating, byte timing, handshake, abort.
// Drives inputs and samples outputs 1 time unit after each rising edge.
// Hand-computed expected results for the two key/state vectors.
module tb_mod_enc_add_round_key;

   localparam int N = 16;

   logic                clk = 1'b0;
   logic                resetn;
   logic                startBit;
   logic                reg163_status;
   logic                reg162_status;
   logic                rd_comp;
   logic [N-1:0][7:0]   p;
   logic [127:0]        k;
   logic [3:0]          round;
   logic [N-1:0][7:0]   o;
   logic                ok;

   int checks = 0;
   int errors = 0;

   logic [127:0]        key2;
   logic [127:0]        key3;
   logic [N-1:0][7:0]   exp2;
   logic [N-1:0][7:0]   exp3;

   always #5 clk = ~clk;

   mod_enc_add_round_key #(.N(N)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .startBit      (startBit),
      .reg163_status (reg163_status),
      .reg162_status (reg162_status),
      .rd_comp       (rd_comp),
      .p             (p),
      .k             (k),
      .round         (round),
      .o             (o),
      .ok            (ok)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      key2 = 128'h00010203040506070809010203040506;
      key3 = 128'h0f0e0d0c0b0a09080706050403020100;
      exp2 = 128'h01000302050407060908000302050407;   // 0x01 in every byte XOR key2
      exp3 = 128'h0d0c0f0e09080b0a0504070601000302;   // 0x02 in every byte XOR key3

      resetn        = 1'b1;
      startBit      = 1'b0;
      reg163_status = 1'b0;
      reg162_status = 1'b0;
      rd_comp       = 1'b0;
      p             = '0;
      k             = '0;
      round         = 4'd0;

      // Reset values
      #12;
      check("reset_o", o, '0);
      check("reset_ok", {127'd0, ok}, 128'd0);
      tick();
      resetn = 1'b0;

      // 1: startBit low never starts a block
      rd_comp       = 1'b1;
      reg163_status = 1'b1;
      k             = 128'h000102030405060708090a0b0c0d0e0f;
      repeat (20) tick();
      check("nostart_o", o, '0);
      check("nostart_ok", {127'd0, ok}, 128'd0);

      // 2: round 0 start ignores reg162_status; byte-by-byte timing
      p        = {N{8'h01}};
      k        = key2;
      round    = 4'd0;
      startBit = 1'b1;
      tick();                                   // start edge S
      check("s2_start_o", o, '0);
      check("s2_start_ok", {127'd0, ok}, 128'd0);
      for (int i = 0; i < N; i++) begin
         tick();                                // edge S+1+i
         check($sformatf("s2_byte%0d", i), {120'd0, o[i]}, {120'd0, exp2[i]});
         if (i < N - 1) begin
            check($sformatf("s2_next%0d", i + 1), {120'd0, o[i + 1]}, 128'd0);
            check($sformatf("s2_ok_low%0d", i), {127'd0, ok}, 128'd0);
         end else begin
            check("s2_ok_high", {127'd0, ok}, 128'd1);
            check("s2_full", o, exp2);
         end
      end
      repeat (3) tick();                        // DONE holds while reg163 stays ready
      check("s2_hold_ok", {127'd0, ok}, 128'd1);
      check("s2_hold_o", o, exp2);

      // 3: result taken, then a round-1 block with reg162 full
      reg163_status = 1'b0;
      tick();
      check("s3_taken_ok", {127'd0, ok}, 128'd0);
      check("s3_taken_o", o, exp2);
      round         = 4'd1;
      reg162_status = 1'b1;
      reg163_status = 1'b1;
      p             = {N{8'h02}};
      k             = key3;
      tick();                                   // start edge S
      check("s3_start_o", o, '0);
      repeat (15) tick();
      check("s3_ok_early", {127'd0, ok}, 128'd0);
      tick();                                   // S+16
      check("s3_ok", {127'd0, ok}, 128'd1);
      check("s3_o", o, exp3);

      // 4: round != 0 with reg162 empty must not start
      reg163_status = 1'b0;
      reg162_status = 1'b0;
      tick();
      check("s4_idle_ok", {127'd0, ok}, 128'd0);
      reg163_status = 1'b1;
      p             = {N{8'hff}};
      repeat (20) tick();
      check("s4_ok", {127'd0, ok}, 128'd0);
      check("s4_o", o, exp3);

      // 5: reset mid-run aborts, then a clean restart completes
      p             = {N{8'h01}};
      k             = key2;
      reg162_status = 1'b1;
      tick();                                   // start edge S
      repeat (4) tick();                        // S+4
      check("s5_byte3", {120'd0, o[3]}, {120'd0, exp2[3]});
      #2;
      resetn = 1'b1;
      #1;
      check("s5_abort_o", o, '0);
      check("s5_abort_ok", {127'd0, ok}, 128'd0);
      tick();
      tick();
      resetn = 1'b0;
      tick();                                   // restart edge S
      repeat (15) tick();
      check("s5_ok_early", {127'd0, ok}, 128'd0);
      tick();
      check("s5_ok", {127'd0, ok}, 128'd1);
      check("s5_o", o, exp2);

      // 6: operands and start inputs changing mid-run have no effect
      reg163_status = 1'b0;
      tick();
      reg163_status = 1'b1;
      p             = {N{8'h02}};
      k             = key3;
      tick();                                   // start edge S
      repeat (2) tick();                        // S+2
      p             = {N{8'h5a}};
      k             = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
      startBit      = 1'b0;
      rd_comp       = 1'b0;
      repeat (13) tick();                       // S+15
      check("s6_ok_early", {127'd0, ok}, 128'd0);
      tick();                                   // S+16
      check("s6_ok", {127'd0, ok}, 128'd1);
      check("s6_o", o, exp3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
